// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared forwarding-select codes, hazard FSM states and the pipeline NOP word.
package pipeline_pkg;
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;
    localparam logic [31:0] NOP        = 32'h0000_0000;
    typedef enum logic {RUN, MD_WAIT} hz_state_t;
endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: loadable down-counter for MULT/DIV occupancy; done pulses on the last busy cycle.
module md_busy_timer #(
    parameter int MD_LATENCY = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic done
);
    localparam int TW = $clog2(MD_LATENCY) + 1;
    logic [TW-1:0] cnt;
    always_ff @(posedge clock) begin
        if (!reset) cnt <= '0;
        else if (start) cnt <= TW'(MD_LATENCY - 1);
        else if (cnt != '0) cnt <= cnt - TW'(1);
    end
    // Entry cycle is occupancy cycle 1, so the last cycle is the one where cnt reads 1.
    assign done = cnt == TW'(1);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/jump/MULT-DIV hazard control and ALU forwarding; HAZARD_PERF_COUNTERS_EN enables stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] fd_rs,
    input  logic [REG_AW-1:0] fd_rt,
    input  logic              fd_use_rs,
    input  logic              fd_use_rt,
    input  logic [REG_AW-1:0] de_rs,
    input  logic [REG_AW-1:0] de_rt,
    input  logic [REG_AW-1:0] de_rd,
    input  logic              de_is_lw,
    input  logic              de_is_md,
    input  logic              jump_taken,
    input  logic [REG_AW-1:0] em_rd,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic              em_wren,
    input  logic              mw_wren,
    output logic              pc_we,
    output logic              fd_we,
    output logic              de_we,
    output logic              fd_flush,
    output logic              de_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              md_busy,
    output logic              md_done,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    hz_state_t state;
    logic run, jmp, md_start, freeze, load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we
    );
        return (src == '0) ? FWD_REGFILE :
               (m_we && m_rd == src) ? FWD_MEM :
               (w_we && w_rd == src) ? FWD_WB : FWD_REGFILE;
    endfunction

    md_busy_timer #(.MD_LATENCY(MD_LATENCY)) u_timer (
        .clock (clock),
        .reset (reset),
        .start (md_start),
        .done  (md_done)
    );

    always_ff @(posedge clock) begin
        if (!reset) state <= RUN;
        else if (md_start) state <= MD_WAIT;
        else if (state == MD_WAIT && md_done) state <= RUN;
    end

    always_comb begin
        run      = state == RUN;
        jmp      = run && jump_taken;
        md_start = run && de_is_md && !jump_taken;
        freeze   = md_start || (!run && !md_done);
        load_use = de_is_lw && de_rd != '0 &&
                   ((fd_use_rs && fd_rs == de_rd) || (fd_use_rt && fd_rt == de_rd));
        pc_we    = jmp || !(freeze || load_use);
        fd_we    = pc_we;
        de_we    = jmp || !freeze;
        fd_flush = jmp;
        de_flush = jmp || (!freeze && load_use);
        md_busy  = !run || de_is_md;
        fwd_a_sel = fwd_sel(de_rs, em_rd, em_wren, mw_rd, mw_wren);
        fwd_b_sel = fwd_sel(de_rt, em_rd, em_wren, mw_rd, mw_wren);
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we) stall_cnt <= stall_cnt + CNT_W'(1);
            if (jmp) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule
